digilock_checker: RTL and testbench

Password-entry checker for the DigiLock datapath. It collects keypad digits, compares them against a stored code when the user confirms, and drives the wrong-attempt counter: one `add` pulse per failed attempt, one `cnt_clr` pulse on success or at the end of a lockout. It reads the counter's saturation flag `s` back, opens the lock for a fixed time on a correct code, and holds a timed lockout once the counter saturates.

---
 rtl/digilock_pkg.sv | 7 +
 rtl/digilock_timer.sv | 21 ++
 rtl/digilock_checker.sv | 117 +++++++++++
 tb/tb_digilock_checker.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/digilock_pkg.sv
// Shared types and constants for the DigiLock password checker.
package digilock_pkg;
   localparam int DIGIT_W    = 4;
   localparam int DEF_DIGITS = 4;

   typedef enum logic [2:0] {ENTRY, FAIL, WAIT_S, OPEN, LOCKOUT} state_t;
endpackage

// File: rtl/digilock_timer.sv
// Loadable down-counter shared by the OPEN and LOCKOUT hold periods.
module digilock_timer #(
   parameter int W = 5
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] value,
   output logic         done
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)              value <= '0;
      else if (load)           value <= load_val;
      else if (value != '0)    value <= value - W'(1);
   end

   assign done = (value == W'(1));

endmodule

// File: rtl/digilock_checker.sv
// Keypad entry collector, code comparator and attempt/lockout sequencer.
module digilock_checker
   import digilock_pkg::*;
#(
   parameter int                            N_DIGITS    = DEF_DIGITS,
   parameter logic [DIGIT_W*N_DIGITS-1:0]   PASSWORD    = 16'h1234,
   parameter int                            OPEN_CYCLES = 8,
   parameter int                            LOCK_CYCLES = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [DIGIT_W-1:0] digit,
   input  logic               digit_valid,
   input  logic               confirm,
   input  logic               s,
   output logic               add,
   output logic               cnt_clr,
   output logic               unlocked,
   output logic               locked
);

   localparam int EW    = DIGIT_W * N_DIGITS;
   localparam int CW    = $clog2(N_DIGITS + 1);
   localparam int T_MAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
   localparam int TW    = $clog2(T_MAX) + 1;

   state_t          state, state_nx;
   logic [EW-1:0]   entry, entry_nx;
   logic [CW-1:0]   cnt, cnt_nx;
   logic            clr_nx;
   logic            tmr_load;
   logic [TW-1:0]   tmr_val, tmr_value;
   logic            tmr_done;

   digilock_timer #(.W(TW)) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load),
      .load_val (tmr_val),
      .value    (tmr_value),
      .done     (tmr_done)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ENTRY;
         entry   <= '0;
         cnt     <= '0;
         cnt_clr <= 1'b0;
      end else begin
         state   <= state_nx;
         entry   <= entry_nx;
         cnt     <= cnt_nx;
         cnt_clr <= clr_nx;
      end
   end

   always_comb begin
      state_nx = state;
      entry_nx = entry;
      cnt_nx   = cnt;
      clr_nx   = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = '0;
      unique case (state)
         ENTRY: begin
            if (confirm) begin
               entry_nx = '0;
               cnt_nx   = '0;
               if (cnt == CW'(N_DIGITS) && entry == PASSWORD) begin
                  state_nx = OPEN;
                  tmr_load = 1'b1;
                  tmr_val  = TW'(OPEN_CYCLES);
                  clr_nx   = 1'b1;
               end else begin
                  state_nx = FAIL;
               end
            // s is stale while a clear is still in flight to the counter
            end else if (s && !cnt_clr) begin
               state_nx = LOCKOUT;
               tmr_load = 1'b1;
               tmr_val  = TW'(LOCK_CYCLES);
               entry_nx = '0;
               cnt_nx   = '0;
            end else if (digit_valid) begin
               entry_nx = (entry << DIGIT_W) | EW'(digit);
               if (cnt != CW'(N_DIGITS)) cnt_nx = cnt + CW'(1);
            end
         end
         FAIL:   state_nx = WAIT_S;
         WAIT_S: begin
            if (s) begin
               state_nx = LOCKOUT;
               tmr_load = 1'b1;
               tmr_val  = TW'(LOCK_CYCLES);
            end else begin
               state_nx = ENTRY;
            end
         end
         OPEN: begin
            if (tmr_done || tmr_value == '0) state_nx = ENTRY;
         end
         LOCKOUT: begin
            if (tmr_done || tmr_value == '0) begin
               state_nx = ENTRY;
               clr_nx   = 1'b1;
            end
         end
         default: state_nx = ENTRY;
      endcase
   end

   assign add      = (state == FAIL);
   assign unlocked = (state == OPEN);
   assign locked   = (state == LOCKOUT);

endmodule

// File: tb/tb_digilock_checker.sv
// Randomized and directed bench for digilock_checker with a schedule-based reference model.
module tb_digilock_checker;
   localparam int OPEN_C = 8;
   localparam int LOCK_C = 16;
   localparam int MAXC   = 8192;

   logic       clk = 0;
   logic       reset = 0;
   logic [3:0] digit = '0;
   logic       digit_valid = 0;
   logic       confirm = 0;
   logic       s;
   logic       add, cnt_clr, unlocked, locked;

   int cyc = 0;
   int n_chk = 0, n_fail = 0;
   int n_add = 0, n_clr = 0, n_unl = 0, n_lock = 0;
   int b_add, b_clr, b_unl, b_lock;
   bit exp_add [MAXC];
   bit exp_clr [MAXC];
   bit exp_unl [MAXC];
   bit exp_lock[MAXC];
   int q[$];
   int fails = 0;
   int accept_from = 0;
   int attempts = 0;
   int pw[4] = '{1, 2, 3, 4};

   digilock_checker #(
      .N_DIGITS(4), .PASSWORD(16'h1234), .OPEN_CYCLES(OPEN_C), .LOCK_CYCLES(LOCK_C)
   ) dut (
      .clk(clk), .reset(reset), .digit(digit), .digit_valid(digit_valid), .confirm(confirm),
      .s(s), .add(add), .cnt_clr(cnt_clr), .unlocked(unlocked), .locked(locked)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // environment attempt counter, saturating after three failures
   always @(posedge clk or negedge reset)
      if (!reset)                      attempts <= 0;
      else if (cnt_clr)                attempts <= 0;
      else if (add && attempts < 3)    attempts <= attempts + 1;
   assign s = (attempts == 3);

   task automatic chk(input string nm, input int act, input int exp_v);
      n_chk++;
      if (act != exp_v) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp_v);
      end
   endtask

   always @(negedge clk) begin
      if (reset && cyc < MAXC) begin
         chk("add", add, exp_add[cyc]);
         chk("cnt_clr", cnt_clr, exp_clr[cyc]);
         chk("unlocked", unlocked, exp_unl[cyc]);
         chk("locked", locked, exp_lock[cyc]);
         n_add  += int'(add);
         n_clr  += int'(cnt_clr);
         n_unl  += int'(unlocked);
         n_lock += int'(locked);
      end
   end

   // Input sampled at edge e; outputs scheduled by sample index (index n = after edge n).
   task automatic model_edge(input int e, input bit dv, input int d, input bit cf);
      bit ok;
      if (e < accept_from) return;
      if (cf) begin
         ok = (q.size() >= 4);
         for (int i = 0; i < 4 && ok; i++)
            if (q[q.size() - 4 + i] != pw[i]) ok = 0;
         q.delete();
         if (ok) begin
            if (e < MAXC) exp_clr[e] = 1;
            for (int k = 0; k < OPEN_C; k++) if (e + k < MAXC) exp_unl[e + k] = 1;
            fails = 0;
            accept_from = e + OPEN_C + 1;
         end else begin
            if (e < MAXC) exp_add[e] = 1;
            fails++;
            if (fails == 3) begin
               for (int k = 2; k < LOCK_C + 2; k++) if (e + k < MAXC) exp_lock[e + k] = 1;
               if (e + LOCK_C + 2 < MAXC) exp_clr[e + LOCK_C + 2] = 1;
               fails = 0;
               accept_from = e + LOCK_C + 3;
            end else begin
               accept_from = e + 3;
            end
         end
      end else if (dv) begin
         q.push_back(d);
      end
   endtask

   task automatic drive(input bit dv, input int d, input bit cf);
      @(negedge clk);
      digit_valid = dv;
      digit       = 4'(d);
      confirm     = cf;
      model_edge(cyc + 1, dv, d, cf);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0);
   endtask

   task automatic enter_code(input int d0, input int d1, input int d2, input int d3);
      drive(1, d0, 0); drive(1, d1, 0); drive(1, d2, 0); drive(1, d3, 0);
      drive(0, 0, 1);
   endtask

   task automatic snap();
      b_add = n_add; b_clr = n_clr; b_unl = n_unl; b_lock = n_lock;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      #2;
      digit_valid = 0;
      confirm     = 0;
      reset       = 0;
      q.delete();
      fails = 0;
      accept_from = 0;
      for (int k = cyc + 1; k < MAXC; k++) begin
         exp_add[k] = 0; exp_clr[k] = 0; exp_unl[k] = 0; exp_lock[k] = 0;
      end
      #1;
      chk("unlocked_at_reset", unlocked, 0);
      chk("locked_at_reset", locked, 0);
      @(negedge clk);
      #2 reset = 1;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      #2 reset = 1;
      @(negedge clk);
      chk("rst_add", add, 0);
      chk("rst_cnt_clr", cnt_clr, 0);
      chk("rst_unlocked", unlocked, 0);
      chk("rst_locked", locked, 0);

      // correct code opens for exactly OPEN_C cycles
      snap();
      enter_code(1, 2, 3, 4);
      idle(12);
      chk("open_cycles", n_unl - b_unl, 8);
      chk("open_clr_pulses", n_clr - b_clr, 1);
      chk("open_add_pulses", n_add - b_add, 0);

      // wrong code then immediate correct code
      snap();
      enter_code(1, 2, 3, 5);
      idle(2);
      enter_code(1, 2, 3, 4);
      idle(12);
      chk("wrong_add_pulses", n_add - b_add, 1);
      chk("wrong_then_open", n_unl - b_unl, 8);

      // three failures -> lockout; keypad ignored while locked
      snap();
      enter_code(9, 9, 9, 9); idle(2);
      enter_code(9, 9, 9, 9); idle(2);
      enter_code(1, 2, 3, 5);
      for (int i = 0; i < 10; i++) drive(1, pw[i % 4], (i % 5) == 4);
      idle(20);
      chk("lock_cycles", n_lock - b_lock, 16);
      chk("lock_add_pulses", n_add - b_add, 3);
      chk("lock_clr_pulses", n_clr - b_clr, 1);
      snap();
      enter_code(1, 2, 3, 4);
      idle(12);
      chk("open_after_lock", n_unl - b_unl, 8);

      // only the last four digits count
      snap();
      drive(1, 1, 0);
      enter_code(1, 2, 3, 4);
      idle(12);
      chk("long_entry_opens", n_unl - b_unl, 8);
      snap();
      drive(1, 1, 0); drive(1, 2, 0); drive(1, 3, 0); drive(0, 0, 1);
      idle(3);
      chk("short_entry_add", n_add - b_add, 1);
      chk("short_entry_unl", n_unl - b_unl, 0);

      // digit together with confirm is dropped
      snap();
      drive(1, 1, 0); drive(1, 2, 0); drive(1, 3, 0); drive(1, 4, 1);
      idle(3);
      chk("dv_confirm_add", n_add - b_add, 1);
      chk("dv_confirm_unl", n_unl - b_unl, 0);

      // reset in OPEN cycle 3, then entry must be empty
      enter_code(1, 2, 3, 4);
      idle(2);
      chk("open_before_reset", unlocked, 1);
      pulse_reset();
      snap();
      drive(0, 0, 1);
      idle(3);
      chk("empty_after_reset", n_add - b_add, 1);
      enter_code(1, 2, 3, 4);
      idle(12);

      // reset in LOCKOUT cycle 5
      enter_code(9, 9, 9, 9); idle(2);
      enter_code(9, 9, 9, 9); idle(2);
      enter_code(9, 9, 9, 9);
      idle(6);
      chk("locked_before_reset", locked, 1);
      pulse_reset();
      snap();
      enter_code(1, 2, 3, 4);
      idle(12);
      chk("open_after_lock_reset", n_unl - b_unl, 8);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         case ($urandom_range(0, 5))
            0:       enter_code(1, 2, 3, ($urandom_range(0, 2) == 0) ? 5 : 4);
            1, 2:    drive(1, $urandom_range(0, 9), 0);
            3:       drive(0, 0, 1);
            4:       drive(1, $urandom_range(0, 9), 1);
            default: idle($urandom_range(1, 6));
         endcase
      end
      idle(30);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
